maxpool_stream: RTL and testbench
=================================

# maxpool_stream

Parametrised, pipelined streaming max-reduction unit for the pooling path. Each accepted beat carries `LANES` elements. A registered comparator tree reduces the beat to its maximum. An accumulation stage then tracks the running maximum and its position across a runtime-programmable window of beats. The unit emits one maximum and one arg-max index per window, with valid/ready handshakes on both sides and full backpressure support.

## Interface
- `DW`, 8, element width in bits
- `LANES`, 4, elements per beat; power of two, ≥ 2; `LW = log2(LANES)`
- `SIGNED`, 0, 0 = unsigned compare, 1 = two's-complement compare
- `CNT_W`, 8, window-length counter width; `IW = CNT_W + LW`
- `clk`  in  1  clock; one clock domain only
- `rst`  in  1  asynchronous, active-high reset
- `clear`  in  1  synchronous abort of all in-flight data
- `win_len`  in  CNT_W  beats per window; 0 is treated as 1
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  input beat accepted when `in_valid && in_ready`
- `in_data`  in  LANES*DW  lane i at `[i*DW +: DW]`
- `out_valid`  out  1  result valid
- `out_ready`  in  1  result consumed when `out_valid && out_ready`
- `out_max`  out  DW  window maximum
- `out_idx`  out  IW  position of the maximum: `beat*LANES + lane`, with `beat` counted from 0 within the window

## Operation
- Global advance: `adv = !out_valid || out_ready`. `in_ready = adv && !clear && !rst`. All stage registers and stage-valid bits update only when `adv` is high.
- Tree: `LW` registered stages. Each stage has a valid bit and carries a (value, lane index) pair per node.
  - Each node compares a lower-index operand a with a higher-index operand b.
  - b wins only if b > a (strict), so ties keep the lower index.
  - Comparison is signed or unsigned according to `SIGNED`.
- Accumulator FSM, with states IDLE and ACC:
  - IDLE, tree output valid: latch `win_len` as `len` (0 → 1). Set `run_max`/`run_idx` to the tree result, with `beat = 0`. Set `cnt = 1`. If `len == 1`, complete the window; otherwise go to ACC.
  - ACC, tree output valid: if the tree value > `run_max` (strict), replace it with index `cnt*LANES + lane`. Increment `cnt`. When `cnt + 1 == len`, complete the window and return to IDLE.
  - Completion: load the final max/index into the output registers and set `out_valid`. The accumulator is free on the same edge, so the next window's first beat is absorbed with no bubble.
- `win_len` must remain stable from a window's first beat until that beat reaches the accumulator. Later changes affect only subsequent windows.
- `clear`: all stage-valid bits → 0, FSM → IDLE, `cnt` → 0, `out_valid` → 0. `clear` takes priority over all handshakes in the same cycle.

## Timing
- Reset (async assert): all stage valids, `out_valid`, `out_max`, `out_idx`, `cnt` → 0; FSM → IDLE. `in_ready` is 0 while `rst` is high and 1 on the first cycle after deassertion.
- Latency: the last beat of a window is accepted at edge E; `out_valid` rises after edge E+LW+1 (3 cycles for LANES=4), provided `adv` stays high.
- Throughput: one beat per cycle while `out_ready` is high. A window of length 1 yields one result per cycle.
- `out_valid` low with `out_ready` low: the pipeline still advances and in-flight data is not stalled.
- `out_valid` high with `out_ready` low: the whole pipeline freezes, and `in_ready` goes low in the same cycle (combinational).
- `out_max`/`out_idx` hold stable while `out_valid && !out_ready`.
- Input is accepted in the same cycle a result is consumed (`out_ready` high). No beats are lost or duplicated.
- Reset mid-window: the partial window is discarded and no output is produced for it.
- `clear` and `in_valid` in the same cycle: the beat is not accepted.

## Test plan
- SIGNED=0, LANES=4, win_len=1, beat {0x12,0x7F,0x7F,0x03} (lane0..3) → out_max=0x7F, out_idx=1, out_valid 3 cycles after acceptance.
- win_len=3, beats {1,2,3,4},{9,0,0,0},{5,9,5,5} → out_max=9, out_idx=4 (tie at idx 9 does not replace); one result only.
- Beat {0x80,0xFF,0x01,0xFE}, win_len=1: SIGNED=1 → 0x01/idx 2; SIGNED=0 → 0xFF/idx 1.
- Backpressure, using 8 back-to-back win_len=1 windows with values 1..8 on lane 3:
  - Hold out_ready low for 5 cycles once out_valid is high → in_ready=0 during the hold and out_max stable.
  - After release, outputs are 1..8 in order with idx 3 each, and none are missing or repeated.
- `clear` pulsed after the 2nd beat of a win_len=4 window, then a fresh win_len=2 window {7,..},{3,..} → single result 7, idx 0. win_len=0 with a single beat → one result per beat.
- `rst` asserted asynchronously mid-window with out_valid high → out_valid/out_max/out_idx read 0 immediately. in_ready=1 one cycle after deassertion, and the next window is reduced correctly.

Source files
------------

// File: rtl/maxpool_stream.sv
// Streaming max-reduction: registered comparator tree per beat, then a windowed
// running-max accumulator that emits one (max, arg-max) pair per window.
module maxpool_stream #(
    parameter int unsigned DW     = 8,
    parameter int unsigned LANES  = 4,
    parameter int unsigned SIGNED = 0,
    parameter int unsigned CNT_W  = 8,
    localparam int unsigned LW    = $clog2(LANES),
    localparam int unsigned IW    = CNT_W + LW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [CNT_W-1:0]      win_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*DW-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DW-1:0]         out_max,
    output logic [IW-1:0]         out_idx
);

    typedef enum logic [0:0] {StIdle, StAcc} state_e;

    // Heap layout: node k has children 2k (lower lanes) and 2k+1; lane i sits at LANES+i.
    logic [DW-1:0]    val_q    [1:2*LANES-1];
    logic [DW-1:0]    val_d    [1:2*LANES-1];
    logic [LW-1:0]    idx_q    [1:LANES-1];
    logic [LW-1:0]    idx_d    [1:LANES-1];
    logic [LW-1:0]    node_idx [1:2*LANES-1];
    logic [LW:0]      vld_q, vld_d;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    run_max_q, run_max_d;
    logic [IW-1:0]    run_idx_q, run_idx_d;
    logic             out_valid_q, out_valid_d;
    logic [DW-1:0]    out_max_q, out_max_d;
    logic [IW-1:0]    out_idx_q, out_idx_d;

    logic             adv;
    logic [DW-1:0]    root_val;
    logic [LW-1:0]    root_idx;
    logic             root_vld;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] win_eff;

    function automatic logic gt(input logic [DW-1:0] b, input logic [DW-1:0] a);
        if (SIGNED != 0) begin
            return $signed(b) > $signed(a);
        end
        return b > a;
    endfunction

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv && !clear && !rst;

    assign out_valid = out_valid_q;
    assign out_max   = out_max_q;
    assign out_idx   = out_idx_q;

    assign root_val = val_q[1];
    assign root_idx = idx_q[1];
    assign root_vld = vld_q[LW];
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign win_eff  = (win_len == '0) ? CNT_W'(1) : win_len;

    always_comb begin
        for (int k = 1; k < LANES; k++) begin
            node_idx[k] = idx_q[k];
        end
        for (int i = 0; i < LANES; i++) begin
            node_idx[LANES+i] = LW'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            val_d[LANES+i] = in_data[i*DW +: DW];
        end
        // Higher-index operand wins only on strict greater, so ties keep the lower index.
        for (int k = 1; k < LANES; k++) begin
            if (gt(val_q[2*k+1], val_q[2*k])) begin
                val_d[k] = val_q[2*k+1];
                idx_d[k] = node_idx[2*k+1];
            end else begin
                val_d[k] = val_q[2*k];
                idx_d[k] = node_idx[2*k];
            end
        end
        vld_d = {vld_q[LW-1:0], in_valid && in_ready};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q <= '{default: '0};
            idx_q <= '{default: '0};
            vld_q <= '0;
        end else begin
            if (adv) begin
                val_q <= val_d;
                idx_q <= idx_d;
            end
            if (clear) begin
                vld_q <= '0;
            end else if (adv) begin
                vld_q <= vld_d;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        run_max_d   = run_max_q;
        run_idx_d   = run_idx_q;
        out_valid_d = out_valid_q;
        out_max_d   = out_max_q;
        out_idx_d   = out_idx_q;

        if (clear) begin
            state_d     = StIdle;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else if (adv) begin
            out_valid_d = 1'b0;
            if (root_vld) begin
                case (state_q)
                    StIdle: begin
                        len_d     = win_eff;
                        run_max_d = root_val;
                        run_idx_d = IW'(root_idx);
                        cnt_d     = CNT_W'(1);
                        if (win_eff == CNT_W'(1)) begin
                            out_valid_d = 1'b1;
                            out_max_d   = root_val;
                            out_idx_d   = IW'(root_idx);
                        end else begin
                            state_d = StAcc;
                        end
                    end
                    StAcc: begin
                        if (gt(root_val, run_max_q)) begin
                            run_max_d = root_val;
                            run_idx_d = {cnt_q, root_idx};
                        end
                        cnt_d = cnt_inc;
                        // Accumulator frees on the completing edge; next window needs no bubble.
                        if (cnt_inc == len_q) begin
                            out_valid_d = 1'b1;
                            out_max_d   = run_max_d;
                            out_idx_d   = run_idx_d;
                            state_d     = StIdle;
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            len_q       <= '0;
            cnt_q       <= '0;
            run_max_q   <= '0;
            run_idx_q   <= '0;
            out_valid_q <= 1'b0;
            out_max_q   <= '0;
            out_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            run_max_q   <= run_max_d;
            run_idx_q   <= run_idx_d;
            out_valid_q <= out_valid_d;
            out_max_q   <= out_max_d;
            out_idx_q   <= out_idx_d;
        end
    end

endmodule

// File: tb/tb_maxpool_stream.sv
// Directed bench for maxpool_stream: unsigned and signed instances share all inputs;
// results of the unsigned instance are collected in handshake order.
module tb_maxpool_stream;

    localparam int unsigned DW    = 8;
    localparam int unsigned LANES = 4;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned IW    = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic [CNT_W-1:0] win_len;
    logic             in_valid;
    logic [31:0]      in_data;
    logic             out_ready;

    logic             in_ready, out_valid;
    logic [DW-1:0]    out_max;
    logic [IW-1:0]    out_idx;
    logic             s_in_ready, s_out_valid;
    logic [DW-1:0]    s_out_max;
    logic [IW-1:0]    s_out_idx;

    int tests = 0;
    int fails = 0;
    logic [DW+IW-1:0] resq [$];

    maxpool_stream #(.DW(DW), .LANES(LANES), .SIGNED(0), .CNT_W(CNT_W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .win_len   (win_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_idx   (out_idx)
    );

    maxpool_stream #(.DW(DW), .LANES(LANES), .SIGNED(1), .CNT_W(CNT_W)) u_dut_s (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .win_len   (win_len),
        .in_valid  (in_valid),
        .in_ready  (s_in_ready),
        .in_data   (in_data),
        .out_valid (s_out_valid),
        .out_ready (out_ready),
        .out_max   (s_out_max),
        .out_idx   (s_out_idx)
    );

    always #5 clk = ~clk;

    // Results are recorded mid-low-phase, after all stimulus for the cycle is settled.
    always begin
        @(negedge clk);
        #3;
        if (!rst && out_valid && out_ready) resq.push_back({out_max, out_idx});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] pack(input logic [7:0] l0, input logic [7:0] l1,
                                         input logic [7:0] l2, input logic [7:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic beat(input logic [31:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        #1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("beat_accept_timeout", 32'(n < 50), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] m, input logic [IW-1:0] i);
        logic [DW+IW-1:0] r;
        if (resq.size() == 0) begin
            check({tag, "_present"}, 32'd0, 32'd1);
        end else begin
            r = resq.pop_front();
            check({tag, "_max"}, 32'(r[DW+IW-1:IW]), 32'(m));
            check({tag, "_idx"}, 32'(r[IW-1:0]), 32'(i));
        end
    endtask

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        win_len   = 8'd1;

        // Reset state
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_out_max", 32'(out_max), 32'd0);
        check("post_rst_out_idx", 32'(out_idx), 32'd0);

        // Single-beat window, tie between lanes 1 and 2, latency
        beat(pack(8'h12, 8'h7F, 8'h7F, 8'h03));
        check("lat_e0", 32'(out_valid), 32'd0);
        tick();
        check("lat_e1", 32'(out_valid), 32'd0);
        tick();
        check("lat_e2", 32'(out_valid), 32'd0);
        tick();
        check("lat_e3_valid", 32'(out_valid), 32'd1);
        check("lat_e3_max", 32'(out_max), 32'h7F);
        check("lat_e3_idx", 32'(out_idx), 32'd1);
        tick(3);
        pop_check("w1", 8'h7F, 10'd1);
        check("w1_count", 32'(resq.size()), 32'd0);

        // Three-beat window, later tie does not replace
        win_len = 8'd3;
        beat(pack(8'd1, 8'd2, 8'd3, 8'd4));
        beat(pack(8'd9, 8'd0, 8'd0, 8'd0));
        beat(pack(8'd5, 8'd9, 8'd5, 8'd5));
        tick(8);
        check("w3_count", 32'(resq.size()), 32'd1);
        pop_check("w3", 8'd9, 10'd4);

        // Signed vs unsigned compare
        win_len = 8'd1;
        beat(pack(8'h80, 8'hFF, 8'h01, 8'hFE));
        tick(3);
        check("sgn_valid", 32'(s_out_valid), 32'd1);
        check("sgn_max", 32'(s_out_max), 32'h01);
        check("sgn_idx", 32'(s_out_idx), 32'd2);
        check("sgn_in_ready", 32'(s_in_ready), 32'd1);
        check("uns_max", 32'(out_max), 32'hFF);
        check("uns_idx", 32'(out_idx), 32'd1);
        tick(3);
        pop_check("uns", 8'hFF, 10'd1);

        // Backpressure: pipeline keeps filling while out_valid is low, then freezes
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) beat(pack(8'd0, 8'd0, 8'd0, 8'(k)));
        in_valid = 1'b1;
        in_data  = pack(8'd0, 8'd0, 8'd0, 8'd5);
        for (int c = 0; c < 5; c++) begin
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_max", 32'(out_max), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        for (int k = 5; k <= 8; k++) beat(pack(8'd0, 8'd0, 8'd0, 8'(k)));
        tick(10);
        check("bp_count", 32'(resq.size()), 32'd8);
        for (int k = 1; k <= 8; k++) pop_check("bp", 8'(k), 10'd3);

        // Clear aborts a partial window and blocks a same-cycle beat
        win_len = 8'd4;
        beat(pack(8'hF0, 8'd0, 8'd0, 8'd0));
        beat(pack(8'd0, 8'hF1, 8'd0, 8'd0));
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = pack(8'hEE, 8'd0, 8'd0, 8'd0);
        win_len  = 8'd2;
        #1;
        check("clr_in_ready", 32'(in_ready), 32'd0);
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        beat(pack(8'd7, 8'd0, 8'd0, 8'd0));
        beat(pack(8'd3, 8'd0, 8'd0, 8'd0));
        tick(8);
        check("clr_count", 32'(resq.size()), 32'd1);
        pop_check("clr", 8'd7, 10'd0);

        // win_len of zero behaves as one
        win_len = 8'd0;
        for (int k = 5; k <= 7; k++) beat(pack(8'd0, 8'd0, 8'(k), 8'd0));
        tick(8);
        check("wl0_count", 32'(resq.size()), 32'd3);
        for (int k = 5; k <= 7; k++) pop_check("wl0", 8'(k), 10'd2);

        // Async reset mid-window while a result is held
        win_len   = 8'd2;
        out_ready = 1'b0;
        beat(pack(8'h11, 8'd0, 8'd0, 8'd0));
        beat(pack(8'd0, 8'h22, 8'd0, 8'd0));
        beat(pack(8'd0, 8'd0, 8'd0, 8'h33));
        tick(2);
        check("prerst_valid", 32'(out_valid), 32'd1);
        check("prerst_max", 32'(out_max), 32'h22);
        check("prerst_idx", 32'(out_idx), 32'd5);
        #1;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_max", 32'(out_max), 32'd0);
        check("arst_idx", 32'(out_idx), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        resq.delete();
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);
        beat(pack(8'h10, 8'h20, 8'h30, 8'h40));
        beat(pack(8'h50, 8'd0, 8'd0, 8'h50));
        tick(8);
        check("rel_count", 32'(resq.size()), 32'd1);
        pop_check("rel", 8'h50, 10'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
